// File: rtl/pipe_event_detector_if.sv
// Frame-event bus between the game logic and pipe_event_detector.
// INVINCIBLE_EN adds the invincible input line.
interface pipe_event_detector_if #(
  parameter int COORD_W = 11
);
  logic               tick;
  logic               restart;
  logic [COORD_W-1:0] bird_x;
  logic [COORD_W-1:0] bird_y;
  logic [COORD_W-1:0] pipe1_x;
  logic [COORD_W-1:0] pipe1_y;
  logic [COORD_W-1:0] pipe2_x;
  logic [COORD_W-1:0] pipe2_y;
`ifdef INVINCIBLE_EN
  logic               invincible;
`endif
  logic               collision;
  logic               pass_pulse;
  logic               game_active;

  modport master (
    output tick, restart, bird_x, bird_y, pipe1_x, pipe1_y, pipe2_x, pipe2_y,
`ifdef INVINCIBLE_EN
    output invincible,
`endif
    input  collision, pass_pulse, game_active
  );

  modport slave (
    input  tick, restart, bird_x, bird_y, pipe1_x, pipe1_y, pipe2_x, pipe2_y,
`ifdef INVINCIBLE_EN
    input  invincible,
`endif
    output collision, pass_pulse, game_active
  );
endinterface

// File: rtl/pipe_event_detector.sv
// Per-frame bird/pipe/floor collision and pipe-pass detection with the game FSM.
// Optional INVINCIBLE_EN masks pipe hits while bus.invincible is high.
module pipe_event_detector #(
  parameter int COORD_W  = 11,
  parameter int BIRD_W   = 16,
  parameter int BIRD_H   = 16,
  parameter int PIPE_W   = 32,
  parameter int GAP_H    = 96,
  parameter int SCREEN_H = 480
) (
  input  logic                  clock,
  input  logic                  reset_n,
  pipe_event_detector_if.slave  bus
);

  typedef logic [COORD_W:0] ext_t;

  localparam ext_t BIRD_W_X   = ext_t'(BIRD_W);
  localparam ext_t BIRD_H_X   = ext_t'(BIRD_H);
  localparam ext_t PIPE_W_X   = ext_t'(PIPE_W);
  localparam ext_t GAP_H_X    = ext_t'(GAP_H);
  localparam ext_t SCREEN_H_X = ext_t'(SCREEN_H);

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  state_t             state;
  logic               collision_q;
  logic               pass_pulse_q;
  logic               game_active_q;
  logic               pending;
  logic [1:0]         prev_behind;

  logic               s1_valid;
  logic [COORD_W-1:0] s1_bird_x, s1_bird_y;
  logic [COORD_W-1:0] s1_pipe1_x, s1_pipe1_y, s1_pipe2_x, s1_pipe2_y;
`ifdef INVINCIBLE_EN
  logic               s1_invincible;
`endif

  logic               s2_valid;
  logic               s2_hit;
  logic [1:0]         s2_behind;

  ext_t bx, by, p1x, p1y, p2x, p2y;
  logic h_ovl1, h_ovl2, out_gap1, out_gap2, floor_hit, pipe_hit, hit_c;
  logic [1:0] behind_c;
  logic [1:0] pass_sum;

  assign bx  = {1'b0, s1_bird_x};
  assign by  = {1'b0, s1_bird_y};
  assign p1x = {1'b0, s1_pipe1_x};
  assign p1y = {1'b0, s1_pipe1_y};
  assign p2x = {1'b0, s1_pipe2_x};
  assign p2y = {1'b0, s1_pipe2_y};

  assign h_ovl1    = (bx + BIRD_W_X > p1x) && (bx < p1x + PIPE_W_X);
  assign h_ovl2    = (bx + BIRD_W_X > p2x) && (bx < p2x + PIPE_W_X);
  assign out_gap1  = (by < p1y) || (by + BIRD_H_X > p1y + GAP_H_X);
  assign out_gap2  = (by < p2y) || (by + BIRD_H_X > p2y + GAP_H_X);
  assign floor_hit = (by + BIRD_H_X >= SCREEN_H_X);
`ifdef INVINCIBLE_EN
  assign pipe_hit  = ~s1_invincible & ((h_ovl1 & out_gap1) | (h_ovl2 & out_gap2));
`else
  assign pipe_hit  = (h_ovl1 & out_gap1) | (h_ovl2 & out_gap2);
`endif
  assign hit_c     = floor_hit | pipe_hit;
  assign behind_c  = {(p2x + PIPE_W_X < bx), (p1x + PIPE_W_X < bx)};

  // Coordinates are captured only on tick; valid bits carry the frame to the outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid   <= 1'b0;
      s1_bird_x  <= '0;
      s1_bird_y  <= '0;
      s1_pipe1_x <= '0;
      s1_pipe1_y <= '0;
      s1_pipe2_x <= '0;
      s1_pipe2_y <= '0;
`ifdef INVINCIBLE_EN
      s1_invincible <= 1'b0;
`endif
      s2_valid   <= 1'b0;
      s2_hit     <= 1'b0;
      s2_behind  <= '0;
    end else begin
      s1_valid <= bus.tick & ~bus.restart;
      if (bus.tick) begin
        s1_bird_x  <= bus.bird_x;
        s1_bird_y  <= bus.bird_y;
        s1_pipe1_x <= bus.pipe1_x;
        s1_pipe1_y <= bus.pipe1_y;
        s1_pipe2_x <= bus.pipe2_x;
        s1_pipe2_y <= bus.pipe2_y;
`ifdef INVINCIBLE_EN
        s1_invincible <= bus.invincible;
`endif
      end
      s2_valid  <= s1_valid & ~bus.restart;
      s2_hit    <= hit_c;
      s2_behind <= behind_c;
    end
  end

  assign pass_sum = {1'b0, pending} + {1'b0, s2_behind[0] & ~prev_behind[0]}
                  + {1'b0, s2_behind[1] & ~prev_behind[1]};

  // A double pass emits one pulse now and parks the second in pending for the next cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      collision_q   <= 1'b0;
      pass_pulse_q  <= 1'b0;
      game_active_q <= 1'b0;
      pending       <= 1'b0;
      prev_behind   <= '1;
    end else begin
      game_active_q <= (state == PLAY);
      if (bus.restart) begin
        state        <= PLAY;
        collision_q  <= 1'b0;
        pass_pulse_q <= 1'b0;
        pending      <= 1'b0;
        prev_behind  <= '1;
      end else begin
        pass_pulse_q <= pending;
        pending      <= 1'b0;
        if (s2_valid) begin
          prev_behind <= s2_behind;
          if (state == PLAY) begin
            if (s2_hit) begin
              state        <= OVER;
              collision_q  <= 1'b1;
              pass_pulse_q <= 1'b0;
              pending      <= 1'b0;
            end else begin
              pass_pulse_q <= |pass_sum;
              pending      <= pass_sum[1];
            end
          end
        end
      end
    end
  end

  assign bus.collision   = collision_q;
  assign bus.pass_pulse  = pass_pulse_q;
  assign bus.game_active = game_active_q;

endmodule

// File: tb/tb_pipe_event_detector.sv
// Directed scenarios plus randomized frames checked against a frame-level reference model.
module tb_pipe_event_detector;

  logic clock;
  logic reset_n;

  pipe_event_detector_if #(.COORD_W(11)) bus ();

  pipe_event_detector #(
    .COORD_W(11), .BIRD_W(16), .BIRD_H(16), .PIPE_W(32), .GAP_H(96), .SCREEN_H(480)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int          cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // A frame's outcome is decided when it is ticked in and lands two edges later.
  typedef struct {
    int land;
    bit hit;
    bit b1;
    bit b2;
  } frame_t;

  frame_t q[$];
  bit m_playing = 0;
  bit m_coll    = 0;
  bit m_pulse   = 0;
  bit m_ga      = 0;
  bit m_prev1   = 1;
  bit m_prev2   = 1;
  int m_owed    = 0;

  function automatic frame_t judge_frame(input int land);
    frame_t f;
    int bx, by, p1x, p1y, p2x, p2y;
    bit pipe1, pipe2, inv;
    bx = int'(bus.bird_x);   by = int'(bus.bird_y);
    p1x = int'(bus.pipe1_x); p1y = int'(bus.pipe1_y);
    p2x = int'(bus.pipe2_x); p2y = int'(bus.pipe2_y);
    inv = 0;
`ifdef INVINCIBLE_EN
    inv = bus.invincible;
`endif
    pipe1 = (bx + 16 > p1x) && (bx < p1x + 32) && ((by < p1y) || (by + 16 > p1y + 96));
    pipe2 = (bx + 16 > p2x) && (bx < p2x + 32) && ((by < p2y) || (by + 16 > p2y + 96));
    f.land = land;
    f.hit  = (by + 16 >= 480) || (!inv && (pipe1 || pipe2));
    f.b1   = (p1x + 32 < bx);
    f.b2   = (p2x + 32 < bx);
    return f;
  endfunction

  task automatic model_edge(input bit tk, input bit rs);
    bit     was_playing;
    bit     killed;
    frame_t f;
    was_playing = m_playing;
    killed = 0;
    if (rs) begin
      m_playing = 1; m_coll = 0; m_pulse = 0; m_owed = 0;
      m_prev1 = 1; m_prev2 = 1;
      q.delete();
    end else begin
      if (q.size() > 0 && q[0].land == cyc) begin
        f = q.pop_front();
        if (m_playing) begin
          if (f.hit) begin
            m_coll = 1; m_playing = 0; m_owed = 0; killed = 1;
          end else begin
            m_owed += int'(f.b1 && !m_prev1) + int'(f.b2 && !m_prev2);
          end
        end
        m_prev1 = f.b1;
        m_prev2 = f.b2;
      end
      if (!killed && m_owed > 0) begin
        m_pulse = 1;
        m_owed--;
      end else begin
        m_pulse = 0;
      end
      if (tk) q.push_back(judge_frame(cyc + 2));
    end
    m_ga = was_playing;
  endtask

  task automatic step(input bit tk, input bit rs);
    bus.tick    = tk;
    bus.restart = rs;
    @(posedge clock);
    cyc++;
    model_edge(tk, rs);
    @(negedge clock);
    bus.tick    = 1'b0;
    bus.restart = 1'b0;
    check($sformatf("collision@%0d", cyc), 32'(bus.collision), 32'(m_coll));
    check($sformatf("pass_pulse@%0d", cyc), 32'(bus.pass_pulse), 32'(m_pulse));
    check($sformatf("game_active@%0d", cyc), 32'(bus.game_active), 32'(m_ga));
  endtask

  task automatic set_coords(input int bx, input int by, input int p1x, input int p1y,
                            input int p2x, input int p2y);
    bus.bird_x  = 11'(bx);
    bus.bird_y  = 11'(by);
    bus.pipe1_x = 11'(p1x);
    bus.pipe1_y = 11'(p1y);
    bus.pipe2_x = 11'(p2x);
    bus.pipe2_y = 11'(p2y);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0);
  endtask

  initial begin
    int last_tick;
    int pulses;
    reset_n     = 1'b0;
    bus.tick    = 1'b0;
    bus.restart = 1'b0;
`ifdef INVINCIBLE_EN
    bus.invincible = 1'b0;
`endif
    set_coords(100, 200, 400, 180, 400, 180);
    repeat (2) @(negedge clock);
    check("rst_collision", 32'(bus.collision), 32'd0);
    check("rst_pass_pulse", 32'(bus.pass_pulse), 32'd0);
    check("rst_game_active", 32'(bus.game_active), 32'd0);
    reset_n = 1'b1;

    // Test 1: restart at cycle 5, game_active from cycle 6
    idle(4);
    step(0, 1);
    check("t1_ga_c5", 32'(bus.game_active), 32'd0);
    step(0, 0);
    check("t1_ga_c6", 32'(bus.game_active), 32'd1);

    // Test 2: inside gap, then above gap
    set_coords(100, 200, 90, 180, 400, 180);
    step(1, 0); idle(3);
    check("t2_no_hit", 32'(bus.collision), 32'd0);
    set_coords(100, 170, 90, 180, 400, 180);
    step(1, 0); step(0, 0);
    check("t2_coll_t1", 32'(bus.collision), 32'd0);
    step(0, 0);
    check("t2_coll_t2", 32'(bus.collision), 32'd1);
    check("t2_ga_t2", 32'(bus.game_active), 32'd1);
    step(0, 0);
    check("t2_ga_t3", 32'(bus.game_active), 32'd0);
    idle(2);

    // Test 3: single pass and re-arm behaviour
    step(0, 1); step(0, 0);
    set_coords(100, 200, 70, 180, 400, 180);
    step(1, 0); idle(3);
    set_coords(100, 200, 67, 180, 400, 180);
    step(1, 0); step(0, 0);
    check("t3_pulse_t1", 32'(bus.pass_pulse), 32'd0);
    step(0, 0);
    check("t3_pulse_t2", 32'(bus.pass_pulse), 32'd1);
    step(0, 0);
    check("t3_pulse_t3", 32'(bus.pass_pulse), 32'd0);
    set_coords(100, 200, 66, 180, 400, 180);
    step(1, 0); idle(3);

    // Test 4: both pipes pass on one tick
    set_coords(100, 200, 70, 180, 70, 180);
    step(1, 0); idle(3);
    set_coords(100, 200, 60, 180, 60, 180);
    step(1, 0); step(0, 0);
    step(0, 0);
    check("t4_pulse_t2", 32'(bus.pass_pulse), 32'd1);
    step(0, 0);
    check("t4_pulse_t3", 32'(bus.pass_pulse), 32'd1);
    step(0, 0);
    check("t4_pulse_t4", 32'(bus.pass_pulse), 32'd0);

    // Test 5: floor boundary
    set_coords(100, 463, 400, 180, 400, 180);
    step(1, 0); idle(3);
    check("t5_463", 32'(bus.collision), 32'd0);
    set_coords(100, 464, 400, 180, 400, 180);
    step(1, 0); idle(2);
    check("t5_464", 32'(bus.collision), 32'd1);
    idle(2);

    // Test 6: restart one cycle after a hitting tick
    step(0, 1); step(0, 0);
    set_coords(100, 170, 90, 180, 400, 180);
    step(1, 0); step(0, 1);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0);
      pulses += int'(bus.pass_pulse);
    end
    check("t6_collision", 32'(bus.collision), 32'd0);
    check("t6_ga", 32'(bus.game_active), 32'd1);
    check("t6_pulses", 32'(pulses), 32'd0);

    // Randomized frames; ticks at least two cycles apart, as frame strobes are.
    last_tick = cyc;
    for (int i = 0; i < 3000; i++) begin
      bit tk, rs;
      if ($urandom_range(15) == 0)
        set_coords($urandom_range(2047), $urandom_range(2047), $urandom_range(2047),
                   $urandom_range(2047), $urandom_range(2047), $urandom_range(2047));
      else
        set_coords($urandom_range(120, 80), $urandom_range(475, 100), $urandom_range(200, 40),
                   $urandom_range(260, 120), $urandom_range(200, 40), $urandom_range(260, 120));
`ifdef INVINCIBLE_EN
      bus.invincible = 1'($urandom_range(1));
`endif
      tk = (cyc - last_tick >= 2) && ($urandom_range(1) == 1);
      rs = m_playing ? ($urandom_range(39) == 0) : ($urandom_range(7) == 0);
      if (tk) last_tick = cyc + 1;
      step(tk, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
